// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb accumulation datapath: default widths, the
// accumulator state encoding and the sum-width derivation.
package xpb_pkg;

  localparam int XPB_WIDTH  = 1024;
  localparam int XPB_LIMB_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    OUTPUT  = 2'd3
  } xpb_state_t;

  // One spare limb above the term width absorbs the growth of up to 2**LIMB_W terms.
  function automatic int sum_w_of(input int width, input int limb_w);
    return width + limb_w;
  endfunction

  function automatic int num_limbs_of(input int width, input int limb_w);
    return sum_w_of(width, limb_w) / limb_w;
  endfunction

endpackage

// File: rtl/csa_3_2.sv
// Combinational 3:2 compressor: folds three W-bit operands into a sum vector
// and an already left-shifted carry vector (top majority bit dropped).
module csa_3_2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign sum   = a ^ b ^ c;
  assign maj   = (a & b) | (a & c) | (b & c);
  assign carry = maj << 1;

endmodule

// File: rtl/xpb_accum_serial.sv
// Carry-save accumulator for xpb terms with a limb-serial carry-propagate
// resolve stage; presents the exact SUM_W-bit sum through a valid/ready port.
module xpb_accum_serial
  import xpb_pkg::*;
#(
  parameter  int WIDTH     = XPB_WIDTH,
  parameter  int LIMB_W    = XPB_LIMB_W,
  parameter  int MAX_TERMS = 32,
  localparam int SUM_W     = sum_w_of(WIDTH, LIMB_W),
  localparam int NUM_LIMBS = num_limbs_of(WIDTH, LIMB_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             term_valid,
  input  logic [WIDTH-1:0] term_data,
  input  logic             term_last,
  output logic             term_ready,
  output logic             sum_valid,
  output logic [SUM_W-1:0] sum_data,
  input  logic             sum_ready,
  output logic             busy,
  output logic             fmt_err
);

  localparam int CNT_W      = $clog2(MAX_TERMS + 1);
  localparam int LIMB_IDX_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  xpb_state_t state;

  logic [SUM_W-1:0]      s_reg;
  logic [SUM_W-1:0]      c_reg;
  logic [SUM_W-1:0]      term_ext;
  logic [SUM_W-1:0]      csa_sum;
  logic [SUM_W-1:0]      csa_carry;
  logic [CNT_W-1:0]      term_cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic [LIMB_IDX_W-1:0] limb_idx;
  logic [LIMB_W-1:0]     limb_sum;
  logic                  cy;
  logic                  cy_next;
  logic                  term_fire;
  logic                  cap_hit;
  logic                  last_limb;

  assign term_ready = (state == ACCUM);
  assign busy       = (state != IDLE);
  assign term_fire  = term_valid & term_ready;
  assign term_ext   = {{(SUM_W - WIDTH){1'b0}}, term_data};
  assign cnt_next   = term_cnt + CNT_W'(1);
  assign cap_hit    = (cnt_next == CNT_W'(MAX_TERMS));
  assign last_limb  = (limb_idx == LIMB_IDX_W'(NUM_LIMBS - 1));

  csa_3_2 #(
    .W (SUM_W)
  ) u_csa (
    .a     (s_reg),
    .b     (c_reg),
    .c     (term_ext),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    limb_sum = '0;
    cy_next  = 1'b0;
    {cy_next, limb_sum} = {1'b0, s_reg[limb_idx*LIMB_W +: LIMB_W]}
                        + {1'b0, c_reg[limb_idx*LIMB_W +: LIMB_W]}
                        + (LIMB_W + 1)'(cy);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_reg     <= '0;
      c_reg     <= '0;
      term_cnt  <= '0;
      limb_idx  <= '0;
      cy        <= 1'b0;
      sum_data  <= '0;
      sum_valid <= 1'b0;
      fmt_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s_reg    <= '0;
            c_reg    <= '0;
            term_cnt <= '0;
            fmt_err  <= 1'b0;
            state    <= ACCUM;
          end
        end

        ACCUM: begin
          if (term_fire) begin
            s_reg    <= csa_sum;
            c_reg    <= csa_carry;
            term_cnt <= cnt_next;
            // Hitting the term cap without a last marker is a framing error.
            if (term_last || cap_hit) begin
              fmt_err  <= ~term_last;
              limb_idx <= '0;
              cy       <= 1'b0;
              state    <= RESOLVE;
            end
          end
        end

        RESOLVE: begin
          sum_data[limb_idx*LIMB_W +: LIMB_W] <= limb_sum;
          cy       <= cy_next;
          limb_idx <= limb_idx + LIMB_IDX_W'(1);
          if (last_limb) begin
            state <= OUTPUT;
          end
        end

        OUTPUT: begin
          // sum_valid is registered, so it rises one edge after the final limb lands.
          if (!sum_valid) begin
            sum_valid <= 1'b1;
          end else if (sum_ready) begin
            sum_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xpb_accum_serial.sv
// Directed and randomized bench for xpb_accum_serial: latency, carry propagation,
// stalls, framing error, async reset, ignored start pulses and a big-integer model.
module tb_xpb_accum_serial;

  localparam int WIDTH = 1024;
  localparam int SUM_W = 1088;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             term_valid = 1'b0;
  logic [WIDTH-1:0] term_data = '0;
  logic             term_last = 1'b0;
  logic             term_ready;
  logic             sum_valid;
  logic [SUM_W-1:0] sum_data;
  logic             sum_ready = 1'b0;
  logic             busy;
  logic             fmt_err;

  int n_cmp = 0;
  int n_bad = 0;

  xpb_accum_serial dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .term_valid (term_valid),
    .term_data  (term_data),
    .term_last  (term_last),
    .term_ready (term_ready),
    .sum_valid  (sum_valid),
    .sum_data   (sum_data),
    .sum_ready  (sum_ready),
    .busy       (busy),
    .fmt_err    (fmt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [SUM_W-1:0] got, input logic [SUM_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driving and sampling happens at the falling edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_term(input logic [WIDTH-1:0] d, input logic last, input int gap);
    repeat (gap) @(negedge clk);
    term_valid = 1'b1;
    term_data  = d;
    term_last  = last;
    for (int i = 0; i < 64 && !term_ready; i++) @(negedge clk);
    if (!term_ready) check("term_ready_wait", term_ready, 1);
    @(negedge clk);
    term_valid = 1'b0;
    term_last  = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit tr_seen);
    lat     = 0;
    tr_seen = 1'b0;
    while (!sum_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (term_ready) tr_seen = 1'b1;
    end
  endtask

  task automatic take_sum(input int hold, output logic [SUM_W-1:0] d, output logic fe,
                          output bit stable);
    d      = sum_data;
    fe     = fmt_err;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (!sum_valid || sum_data !== d || fmt_err !== fe || term_ready) stable = 1'b0;
    end
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] rand_term();
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH / 32; i++) r[i*32 +: 32] = $urandom;
    if ($urandom_range(0, 7) == 0) r = '1;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SUM_W-1:0] got;
    logic [SUM_W-1:0] exp;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] t;
    logic             fe;
    bit               stable;
    bit               tr_seen;
    int               lat;

    ones = '1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_term_ready", term_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_fmt_err", fmt_err, 0);
    check("rst_sum_data", sum_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_term_ready", term_ready, 0);

    // 1: single all-ones term, latency
    do_start();
    check("accum_term_ready", term_ready, 1);
    check("accum_busy", busy, 1);
    send_term(ones, 1'b1, 0);
    wait_valid(lat, tr_seen);
    check("t1_latency", lat, 18);
    check("t1_term_ready_resolve", tr_seen, 0);
    take_sum(0, got, fe, stable);
    check("t1_sum", got, {64'd0, ones});
    check("t1_fmt_err", fe, 0);
    check("t1_pulse_drop", sum_valid, 0);
    check("t1_idle", busy, 0);

    // 2: eight all-ones terms, carry through every limb
    do_start();
    for (int i = 0; i < 8; i++) send_term(ones, i == 7, 0);
    wait_valid(lat, tr_seen);
    take_sum(0, got, fe, stable);
    exp = (SUM_W'(1) << 1027) - SUM_W'(8);
    check("t2_sum", got, exp);
    check("t2_fmt_err", fe, 0);

    // 3: gapped terms, sum_ready held off
    do_start();
    t = '0;
    t[1023] = 1'b1;
    send_term(ones, 1'b0, 3);
    send_term(WIDTH'(1), 1'b0, 3);
    send_term(WIDTH'(5), 1'b0, 3);
    send_term(t, 1'b1, 3);
    wait_valid(lat, tr_seen);
    check("t3_term_ready_resolve", tr_seen, 0);
    take_sum(5, got, fe, stable);
    exp = '0;
    exp[1024] = 1'b1;
    exp[1023] = 1'b1;
    exp[2:0]  = 3'd5;
    check("t3_sum", got, exp);
    check("t3_stable", stable, 1);
    check("t3_done", sum_valid, 0);

    // 4: 32 terms with no last marker
    do_start();
    for (int i = 0; i < 32; i++) send_term(WIDTH'(1), 1'b0, 0);
    check("t4_forced_resolve", term_ready, 0);
    wait_valid(lat, tr_seen);
    take_sum(0, got, fe, stable);
    check("t4_sum", got, 32);
    check("t4_fmt_err", fe, 1);

    // 5: asynchronous reset in the middle of RESOLVE
    do_start();
    send_term(ones, 1'b1, 0);
    repeat (5) @(negedge clk);
    check("t5_in_resolve", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_sum_valid", sum_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_term_ready", term_ready, 0);
    check("t5_rst_fmt_err", fmt_err, 0);
    check("t5_rst_sum_data", sum_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    send_term(WIDTH'(5), 1'b1, 0);
    wait_valid(lat, tr_seen);
    take_sum(0, got, fe, stable);
    check("t5_sum", got, 5);

    // 6: start during ACCUM and OUTPUT is ignored
    do_start();
    send_term(WIDTH'(7), 1'b0, 0);
    start = 1'b1;
    send_term(WIDTH'(9), 1'b0, 0);
    start = 1'b0;
    send_term(WIDTH'(11), 1'b1, 0);
    wait_valid(lat, tr_seen);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6_hold_valid", sum_valid, 1);
    take_sum(2, got, fe, stable);
    check("t6_sum", got, 27);
    check("t6_stable", stable, 1);
    @(negedge clk);
    check("t6_back_idle", busy, 0);

    // Random runs against a big-integer model
    for (int run = 0; run < 1000; run++) begin
      int n;
      bit no_last;
      n       = $urandom_range(1, 32);
      no_last = (n == 32) && ($urandom_range(0, 1) == 1);
      exp     = '0;
      do_start();
      for (int k = 0; k < n; k++) begin
        t   = rand_term();
        exp = exp + {64'd0, t};
        send_term(t, (k == n - 1) && !no_last, ($urandom_range(0, 7) == 0) ? 1 : 0);
      end
      wait_valid(lat, tr_seen);
      if (!sum_valid) check("rand_valid_timeout", sum_valid, 1);
      take_sum($urandom_range(0, 2), got, fe, stable);
      check($sformatf("rand_sum_%0d", run), got, exp);
      check($sformatf("rand_fmt_err_%0d", run), fe, no_last);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
